// File: rtl/br_redirect_ctrl.sv
// Branch redirect sequencer: turns an EX mispredict into a held IF redirect plus flushes,
// and queues per-slot predictor training updates for the BPU to drain.
module br_redirect_ctrl #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ex_br,
   input  logic        ex_br_a,
   input  logic [31:0] ex_pc_br,
   input  logic        stall_dcache_buf,
   input  logic        upd_valid_a,
   input  logic        upd_valid_b,
   input  logic [31:0] upd_pc_a,
   input  logic [31:0] upd_pc_b,
   input  logic [31:0] upd_target_a,
   input  logic [31:0] upd_target_b,
   input  logic        upd_taken_a,
   input  logic        upd_taken_b,
   input  logic        if_ready,
   input  logic        bpu_upd_ready,
   output logic        redir_valid,
   output logic [31:0] redir_pc,
   output logic        flush_front,
   output logic        flush_ex_b,
   output logic        upd_stall,
   output logic        bpu_upd_valid,
   output logic [31:0] bpu_upd_pc,
   output logic [31:0] bpu_upd_target,
   output logic        bpu_upd_taken,
   output logic [31:0] mispred_cnt
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      REDIR = 1'b1
   } state_t;

   state_t          r_state;
   logic [31:0]     r_redir_pc;
   logic [31:0]     r_mispred_cnt;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic [31:0]     r_pc  [DEPTH];
   logic [31:0]     r_tgt [DEPTH];
   logic            r_tkn [DEPTH];

   logic            w_stall;
   logic            w_en;
   logic            w_accept;
   logic            w_push_a;
   logic            w_push_b;
   logic            w_pop;
   logic [1:0]      w_npush;
   logic [AW-1:0]   w_wr_ptr_b;

   // Stall uses the registered occupancy only; a same-cycle pop does not relieve it.
   assign w_stall    = (32'(DEPTH) - 32'(r_count)) < 32'd2;
   assign w_en       = ~stall_dcache_buf & ~w_stall;
   assign w_accept   = ex_br & w_en & (r_state == IDLE);
   assign w_push_a   = w_en & upd_valid_a;
   assign w_push_b   = w_en & upd_valid_b & ~(w_accept & ex_br_a);
   assign w_pop      = (r_count != '0) & bpu_upd_ready;
   assign w_npush    = {1'b0, w_push_a} + {1'b0, w_push_b};
   assign w_wr_ptr_b = w_push_a ? (r_wr_ptr + AW'(1)) : r_wr_ptr;

   assign redir_valid    = (r_state == REDIR);
   assign redir_pc       = r_redir_pc;
   assign mispred_cnt    = r_mispred_cnt;
   assign flush_front    = w_accept | (r_state == REDIR);
   assign flush_ex_b     = w_accept & ex_br_a;
   assign upd_stall      = w_stall;
   assign bpu_upd_valid  = (r_count != '0);
   assign bpu_upd_pc     = r_pc[r_rd_ptr];
   assign bpu_upd_target = r_tgt[r_rd_ptr];
   assign bpu_upd_taken  = r_tkn[r_rd_ptr];

   // Redirect FSM; wrong-path mispredicts seen while in REDIR are dropped.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state       <= IDLE;
         r_redir_pc    <= '0;
         r_mispred_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state       <= REDIR;
                  r_redir_pc    <= ex_pc_br;
                  r_mispred_cnt <= r_mispred_cnt + 32'd1;
               end
            end
            REDIR: begin
               if (if_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Update FIFO control; slot A is older and is written first.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_npush);
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_npush) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_a) begin
         r_pc[r_wr_ptr]  <= upd_pc_a;
         r_tgt[r_wr_ptr] <= upd_target_a;
         r_tkn[r_wr_ptr] <= upd_taken_a;
      end
      if (w_push_b) begin
         r_pc[w_wr_ptr_b]  <= upd_pc_b;
         r_tgt[w_wr_ptr_b] <= upd_target_b;
         r_tkn[w_wr_ptr_b] <= upd_taken_b;
      end
   end

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Scoreboard bench for br_redirect_ctrl: directed scenarios followed by random traffic,
// checked against a queue-based reference model of redirect and update behaviour.
module tb_br_redirect_ctrl;

   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic        rstn, ex_br, ex_br_a, dstall;
      logic [31:0] ex_pc;
      logic        va, vb, ka, kb;
      logic [31:0] pa, pb, ta, tb;
      logic        if_ready, bpu_ready;
   } stim_t;

   typedef struct {
      logic        redir_valid;
      logic [31:0] redir_pc;
      logic        flush_front, flush_ex_b, upd_stall, bpu_valid;
      logic [31:0] mispred_cnt;
   } cyc_t;

   typedef struct {
      logic [31:0] pc, tgt;
      logic        tkn;
   } upd_t;

   logic        clk = 1'b0;
   logic        rstn, ex_br, ex_br_a, stall_dcache_buf;
   logic [31:0] ex_pc_br;
   logic        upd_valid_a, upd_valid_b, upd_taken_a, upd_taken_b;
   logic [31:0] upd_pc_a, upd_pc_b, upd_target_a, upd_target_b;
   logic        if_ready, bpu_upd_ready;
   logic        redir_valid, flush_front, flush_ex_b, upd_stall;
   logic        bpu_upd_valid, bpu_upd_taken;
   logic [31:0] redir_pc, bpu_upd_pc, bpu_upd_target, mispred_cnt;

   br_redirect_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .ex_br(ex_br), .ex_br_a(ex_br_a), .ex_pc_br(ex_pc_br),
      .stall_dcache_buf(stall_dcache_buf),
      .upd_valid_a(upd_valid_a), .upd_valid_b(upd_valid_b),
      .upd_pc_a(upd_pc_a), .upd_pc_b(upd_pc_b),
      .upd_target_a(upd_target_a), .upd_target_b(upd_target_b),
      .upd_taken_a(upd_taken_a), .upd_taken_b(upd_taken_b),
      .if_ready(if_ready), .bpu_upd_ready(bpu_upd_ready),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .flush_front(flush_front), .flush_ex_b(flush_ex_b), .upd_stall(upd_stall),
      .bpu_upd_valid(bpu_upd_valid), .bpu_upd_pc(bpu_upd_pc),
      .bpu_upd_target(bpu_upd_target), .bpu_upd_taken(bpu_upd_taken),
      .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   bit   chk_on = 1'b0;

   cyc_t        exp_cyc[$];
   upd_t        exp_upd[$];
   logic [31:0] exp_redir[$];

   // Reference model state
   upd_t        m_fifo[$];
   bit          m_redir;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard queues.
   always @(negedge clk) begin
      if (chk_on) begin
         if (exp_cyc.size() != 0) begin
            cyc_t e;
            e = exp_cyc.pop_front();
            chk("redir_valid", 32'(redir_valid), 32'(e.redir_valid));
            chk("redir_pc", redir_pc, e.redir_pc);
            chk("flush_front", 32'(flush_front), 32'(e.flush_front));
            chk("flush_ex_b", 32'(flush_ex_b), 32'(e.flush_ex_b));
            chk("upd_stall", 32'(upd_stall), 32'(e.upd_stall));
            chk("bpu_upd_valid", 32'(bpu_upd_valid), 32'(e.bpu_valid));
            chk("mispred_cnt", mispred_cnt, e.mispred_cnt);
         end
         if (bpu_upd_valid === 1'b1 && bpu_upd_ready === 1'b1) begin
            if (exp_upd.size() == 0) begin
               chk("unexpected_upd_pop", 32'(bpu_upd_valid), 32'd0);
            end else begin
               upd_t u;
               u = exp_upd.pop_front();
               chk("bpu_upd_pc", bpu_upd_pc, u.pc);
               chk("bpu_upd_target", bpu_upd_target, u.tgt);
               chk("bpu_upd_taken", 32'(bpu_upd_taken), 32'(u.tkn));
            end
         end
         if (redir_valid === 1'b1 && if_ready === 1'b1) begin
            if (exp_redir.size() == 0) begin
               chk("unexpected_redirect", 32'(redir_valid), 32'd0);
            end else begin
               chk("redir_handshake_pc", redir_pc, exp_redir.pop_front());
            end
         end
      end
   end

   function automatic stim_t idle_s();
      stim_t s;
      s.rstn = 1'b1; s.ex_br = 1'b0; s.ex_br_a = 1'b0; s.dstall = 1'b0; s.ex_pc = '0;
      s.va = 1'b0; s.vb = 1'b0; s.ka = 1'b0; s.kb = 1'b0;
      s.pa = '0; s.pb = '0; s.ta = '0; s.tb = '0;
      s.if_ready = 1'b0; s.bpu_ready = 1'b0;
      return s;
   endfunction

   function automatic stim_t rand_s(input int rst_pct);
      stim_t s;
      s.rstn      = ($urandom_range(99) >= rst_pct);
      s.ex_br     = ($urandom_range(3) == 0);
      s.ex_br_a   = $urandom_range(1) == 1;
      s.dstall    = ($urandom_range(4) == 0);
      s.ex_pc     = {$urandom(), 2'b00} & 32'hffff_fffc;
      s.va        = $urandom_range(1) == 1;
      s.vb        = $urandom_range(1) == 1;
      s.ka        = $urandom_range(1) == 1;
      s.kb        = $urandom_range(1) == 1;
      s.pa        = $urandom();
      s.pb        = $urandom();
      s.ta        = $urandom();
      s.tb        = $urandom();
      s.if_ready  = ($urandom_range(2) != 0);
      s.bpu_ready = ($urandom_range(2) == 0);
      return s;
   endfunction

   function automatic upd_t mk_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tkn);
      upd_t u;
      u.pc = pc; u.tgt = tgt; u.tkn = tkn;
      return u;
   endfunction

   // Drive one cycle, predict its outputs from the model, then advance the model past the edge.
   task automatic step(input stim_t s);
      cyc_t e;
      bit   stall, en, acc;
      rstn = s.rstn; ex_br = s.ex_br; ex_br_a = s.ex_br_a; ex_pc_br = s.ex_pc;
      stall_dcache_buf = s.dstall;
      upd_valid_a = s.va; upd_valid_b = s.vb; upd_taken_a = s.ka; upd_taken_b = s.kb;
      upd_pc_a = s.pa; upd_pc_b = s.pb; upd_target_a = s.ta; upd_target_b = s.tb;
      if_ready = s.if_ready; bpu_upd_ready = s.bpu_ready;

      stall = (int'(DEPTH) - m_fifo.size()) < 2;
      en    = !s.dstall && !stall;
      acc   = s.ex_br && en && !m_redir;
      e.redir_valid = m_redir;
      e.redir_pc    = m_pc;
      e.flush_front = acc || m_redir;
      e.flush_ex_b  = acc && s.ex_br_a;
      e.upd_stall   = stall;
      e.bpu_valid   = (m_fifo.size() != 0);
      e.mispred_cnt = m_cnt;
      exp_cyc.push_back(e);
      if (m_fifo.size() != 0 && s.bpu_ready) exp_upd.push_back(m_fifo.pop_front());
      if (m_redir && s.if_ready) exp_redir.push_back(m_pc);

      if (!s.rstn) begin
         m_fifo.delete();
         m_redir = 1'b0; m_pc = '0; m_cnt = '0;
      end else begin
         if (en && s.va) m_fifo.push_back(mk_upd(s.pa, s.ta, s.ka));
         if (en && s.vb && !(acc && s.ex_br_a)) m_fifo.push_back(mk_upd(s.pb, s.tb, s.kb));
         if (acc) begin
            m_redir = 1'b1; m_pc = s.ex_pc; m_cnt = m_cnt + 32'd1;
         end else if (m_redir && s.if_ready) begin
            m_redir = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      stim_t s;
      s = idle_s();
      s.bpu_ready = 1'b1; s.if_ready = 1'b1;
      repeat (DEPTH + 2) step(s);
   endtask

   initial begin
      stim_t s;
      s = idle_s();
      s.rstn = 1'b0;
      rstn = 1'b0; ex_br = 1'b0; ex_br_a = 1'b0; ex_pc_br = '0; stall_dcache_buf = 1'b0;
      upd_valid_a = 1'b0; upd_valid_b = 1'b0; upd_taken_a = 1'b0; upd_taken_b = 1'b0;
      upd_pc_a = '0; upd_pc_b = '0; upd_target_a = '0; upd_target_b = '0;
      if_ready = 1'b0; bpu_upd_ready = 1'b0;
      m_redir = 1'b0; m_pc = '0; m_cnt = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_on = 1'b1;

      // Reset then idle
      step(s);
      s = idle_s();
      repeat (2) step(s);

      // Slot-A mispredict with both slots valid; IF holds off three cycles
      s = idle_s();
      s.ex_br = 1'b1; s.ex_br_a = 1'b1; s.ex_pc = 32'h1c00_0040;
      s.va = 1'b1; s.vb = 1'b1; s.pa = 32'h0000_1000; s.ta = 32'h1c00_0040; s.ka = 1'b1;
      s.pb = 32'h0000_1004; s.tb = 32'h0000_2000; s.kb = 1'b1;
      step(s);
      s = idle_s();
      repeat (3) step(s);
      s.if_ready = 1'b1;
      step(s);
      s = idle_s();
      step(s);
      drain();

      // dcache stall masks accept and pushes
      s = idle_s();
      s.dstall = 1'b1; s.ex_br = 1'b1; s.ex_pc = 32'h0000_3000; s.va = 1'b1; s.vb = 1'b1;
      step(s);
      s = idle_s();
      step(s);

      // Fill FIFO with three double pushes, then drain in order
      for (int i = 0; i < 3; i++) begin
         s = idle_s();
         s.va = 1'b1; s.vb = 1'b1;
         s.pa = 32'h100 + 32'(i * 16); s.ta = 32'ha00 + 32'(i); s.ka = 1'b1;
         s.pb = 32'h104 + 32'(i * 16); s.tb = 32'hb00 + 32'(i); s.kb = 1'b0;
         step(s);
      end
      drain();

      // Second mispredict while redirect is pending is dropped
      s = idle_s();
      s.ex_br = 1'b1; s.ex_pc = 32'h0000_1000;
      step(s);
      s.ex_pc = 32'h0000_2000;
      step(s);
      s = idle_s();
      s.if_ready = 1'b1;
      step(s);
      s = idle_s();
      step(s);

      // Reset during REDIR with three queued entries
      s = idle_s();
      s.ex_br = 1'b1; s.ex_pc = 32'h0000_4000; s.va = 1'b1; s.vb = 1'b1;
      s.pa = 32'h40; s.pb = 32'h44;
      step(s);
      s = idle_s();
      s.va = 1'b1; s.pa = 32'h48;
      step(s);
      s = idle_s();
      s.rstn = 1'b0;
      step(s);
      s = idle_s();
      repeat (2) step(s);

      // Random traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         s = rand_s(1);
         step(s);
      end
      drain();

      @(negedge clk);
      #1;
      chk("exp_cyc_leftover", 32'(exp_cyc.size()), 32'd0);
      chk("exp_upd_leftover", 32'(exp_upd.size()), 32'd0);
      chk("exp_redir_leftover", 32'(exp_redir.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/br_redirect_ctrl.md
Name: br_redirect_ctrl

Overview:
- Sequences branch-resolution results from the dual-issue EX branch unit toward the frontend and the branch predictor.
- Converts a one-cycle mispredict indication into a held redirect request for IF and generates pipeline flush controls.
- Queues per-slot predictor training updates in a small FIFO that the BPU drains one entry per cycle.
- Sits between the EX-stage branch unit and the IF/BPU.

Parameters:
- DEPTH, 4, update-FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- ex_br  in  1  EX mispredict, either slot (already masked by the branch unit during dcache stall)
- ex_br_a  in  1  slot A is the mispredicting instruction
- ex_pc_br  in  32  corrected fetch PC
- stall_dcache_buf  in  1  MEM dcache stall; EX held
- upd_valid_a / upd_valid_b  in  1  slot carries a resolved branch (br_type≠0)
- upd_pc_a / upd_pc_b  in  32  branch PC
- upd_target_a / upd_target_b  in  32  resolved target
- upd_taken_a / upd_taken_b  in  1  resolved direction
- if_ready  in  1  IF accepts redirect this cycle
- bpu_upd_ready  in  1  BPU consumes head entry
- redir_valid  out  1  redirect pending to IF
- redir_pc  out  32  redirect target
- flush_front  out  1  kill IF/ID contents
- flush_ex_b  out  1  kill EX slot B (slot-A redirect)
- upd_stall  out  1  FIFO cannot absorb two pushes; hold EX
- bpu_upd_valid  out  1  FIFO non-empty
- bpu_upd_pc  out  32  head PC
- bpu_upd_target  out  32  head target
- bpu_upd_taken  out  1  head direction
- mispred_cnt  out  32  accepted mispredict count

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE; FIFO empty (rd/wr pointers 0, count 0); redir_valid=0, redir_pc=0, mispred_cnt=0. All outputs derived from state/FIFO are therefore 0.
- upd_stall = (DEPTH − count < 2), using the registered count at cycle start. It is not relieved by a same-cycle pop.
- en = ~stall_dcache_buf & ~upd_stall.
- accept = ex_br & en & (state==IDLE).
- State machine:
  - IDLE: on accept, go to REDIR; latch redir_pc←ex_pc_br; mispred_cnt+1 (wraps at 2^32).
  - REDIR: redir_valid=1 and redir_pc stable. Go to IDLE on the edge where if_ready=1.
  - ex_br while in REDIR is ignored (wrong-path); no latch, no count.
- redir_valid is registered: it asserts one cycle after accept.
- flush_front = accept | (state==REDIR). It is combinational and stays high through the cycle if_ready is seen.
- flush_ex_b = accept & ex_br_a.
- Push rules (only when en):
  - Slot A pushes if upd_valid_a.
  - Slot B pushes if upd_valid_b & ~(accept & ex_br_a).
  - When both push, A is written first (older). 0, 1 or 2 pushes per cycle.
- Update pushes are also blocked in REDIR when state was entered this cycle? No: they are gated only by en. Wrong-path EX slots are already bubbles after the flush.
- Pop: bpu_upd_valid = (count≠0). On bpu_upd_valid & bpu_upd_ready the head is removed. The bpu_upd_* fields show the head entry combinationally.
- Push and pop in the same cycle are both applied: count_next = count + pushes − pop.
- Pointers wrap modulo DEPTH. Full FIFO plus pop plus no push is legal. Count never exceeds DEPTH, guaranteed by upd_stall.
- Reset mid-REDIR or with a non-empty FIFO discards everything; no update is emitted after reset.

Test Plan:
- Reset then idle → all outputs 0; bpu_upd_valid=0; upd_stall=0.
- ex_br=1, ex_br_a=1, ex_pc_br=0x1c000040, upd_valid_a/b=1, if_ready=0 for 3 cycles then 1:
  - flush_front=1 and flush_ex_b=1 in the accept cycle.
  - redir_valid=1 with redir_pc=0x1c000040 for 4 cycles, then 0.
  - Exactly 1 FIFO entry (slot A); mispred_cnt=1.
- stall_dcache_buf=1 with ex_br=1 and both upd_valid → no accept, no push, state stays IDLE.
- DEPTH=4, bpu_upd_ready=0, three cycles of two pushes:
  - count=2 after cycle 1; upd_stall=1 at count=3 and 4.
  - Third pair not pushed.
  - Raise bpu_upd_ready → entries pop in order A0,B0,A1,B1, then bpu_upd_valid=0.
- Second ex_br while in REDIR (pc 0x2000) → ignored; redir_pc keeps its first value; mispred_cnt unchanged.
- Assert rstn=0 during REDIR with 3 queued entries → next cycle redir_valid=0, bpu_upd_valid=0, mispred_cnt=0.
